multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle sequencer for the MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut regs.
//  Decodes IR[31:26] each instruction and steps the datapath through FETCH..WRITEBACK.
//  Drives every datapath control strobe as a Moore function of state.
//  Stalls on memory handshake, counts retired instructions, traps illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a memory state waits for mem_ready before FAULT (1..255)
//  CNT_W        32  width of instr_count
// PORTS
//  CLK          in   1      rising-edge clock
//  RST_N        in   1      asynchronous, active-low reset
//  op           in   6      IR[31:26], valid from DECODE onward
//  zf           in   1      ALU zero flag
//  mem_ready    in   1      memory completes the current access this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if zf (beq)
//  IorD         out  1      0=PC, 1=ALUOut as memory address
//  MemRead      out  1      memory read request (held until mem_ready)
//  MemWrite     out  1      memory write request (held until mem_ready)
//  IRWrite      out  1      load IR
//  MemToReg     out  1      0=ALUOut, 1=MDR to write-data
//  RegDst       out  1      0=rt, 1=rd
//  RegWrite     out  1      register bank write enable
//  ALUSrcA      out  1      0=PC, 1=A
//  ALUSrcB      out  2      00=B, 01=4, 10=signext, 11=signext<<2
//  AluOp        out  2      00=add, 01=sub, 10=funct-decoded
//  PCSource     out  2      00=ALU, 01=ALUOut, 10=jump target
//  illegal_op   out  1      1-cycle pulse on unknown opcode
//  fault        out  1      sticky; memory timeout occurred
//  instr_count  out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  RST_N low: state=RESET, all outputs 0, instr_count=0, fault=0, timer=0. RESET->FETCH next clock.
//  FETCH: MemRead=1,IorD=0,ALUSrcA=0,ALUSrcB=01,AluOp=00,PCSource=00. IRWrite,PCWrite=1 only in
//   the cycle mem_ready=1, then ->DECODE; otherwise stay.
//  DECODE: ALUSrcA=0,ALUSrcB=11,AluOp=00. op: 100011/101011->MEM_ADDR; 000000->EXEC_R;
//   000100->BRANCH; 000010->JUMP; 001000->ADDI_EX; other->FETCH with illegal_op=1 (not counted).
//  MEM_ADDR: ALUSrcA=1,ALUSrcB=10,AluOp=00 -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: MemRead=1,IorD=1; on mem_ready ->MEM_WB. MEM_WB: RegWrite=1,MemToReg=1,RegDst=0.
//  MEM_WR: MemWrite=1,IorD=1; on mem_ready retire ->FETCH.
//  EXEC_R: ALUSrcA=1,ALUSrcB=00,AluOp=10 ->R_WB. R_WB: RegWrite=1,RegDst=1,MemToReg=0.
//  ADDI_EX: ALUSrcA=1,ALUSrcB=10,AluOp=00 ->ADDI_WB. ADDI_WB: RegWrite=1,RegDst=0,MemToReg=0.
//  BRANCH: ALUSrcA=1,ALUSrcB=00,AluOp=01,PCWriteCond=1,PCSource=01. JUMP: PCWrite=1,PCSource=10.
//  MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP and accepted MEM_WR retire: instr_count+1, ->FETCH.
//  Latency (mem_ready tied 1): R/addi 4, lw 5, sw 4, beq 3, j 3 cycles.
//  Wait timer: clears on entry to FETCH/MEM_RD/MEM_WR and on mem_ready; counts while waiting;
//   reaching MEM_TIMEOUT without mem_ready -> FAULT. FAULT: all strobes 0, fault=1, exit only by reset.
//  mem_ready outside a memory state is ignored. MemRead and MemWrite never both 1.
//  Reset mid-instruction: immediate abort to RESET, no partial write strobe after RST_N falls.
//  instr_count at 2^CNT_W-1 wraps to 0 on next retire.
// STRUCTURE
//  mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//   state encoding localparams, AluOp/ALUSrcB/PCSource code constants.
//  Sub-module mem_wait_timer (clear, enable, MEM_TIMEOUT -> expired); rest is one FSM + output decode.
// TESTING
//  Reset then mem_ready=1, op=000000 -> FETCH,DECODE,EXEC_R,R_WB; RegWrite=1,RegDst=1 in cycle 4; count=1.
//  op=100011, mem_ready low 3 cycles in MEM_RD -> MemRead,IorD held 3 cycles; MEM_WB one cycle later; 5+3 cycles.
//  op=000100 with zf=1 then zf=0 -> PCWriteCond=1,PCSource=01 in BRANCH both times; PCWrite stays 0.
//  op=111111 -> illegal_op pulses once at DECODE exit, back to FETCH, instr_count unchanged.
//  MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 waits, fault=1 sticky, strobes 0 until RST_N.
//  RST_N low during MEM_WR -> MemWrite drops same cycle; count preset 2^CNT_W-1 + j retire -> 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes, state
// encoding, and the datapath mux/ALU control codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Wait timer width; timeouts are limited to 1..255 cycles
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake
  function automatic logic is_mem_state(input state_t s);
    return (s inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready.
// Ports: clk, rst_n (async active-low), clear (zero the count), enable (one
// more wait cycle), expired_c (this wait cycle is the MEM_TIMEOUT-th).
module mem_wait_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [TIMER_W-1:0] count;

  // Wait-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  // count holds the waits already seen, so the current wait is count+1
  assign expired_c = enable && (count == TIMER_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: steps the shared-memory datapath through
// FETCH..WRITEBACK, stalls on mem_ready, counts retired instructions, traps
// illegal opcodes and memory timeouts.
// Ports: CLK, RST_N (async active-low); op = IR[31:26]; zf ALU zero flag;
// mem_ready memory handshake; datapath strobes PCWrite..PCSource; illegal_op
// pulse; fault sticky timeout flag; instr_count retired-instruction counter.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       op,
  input  logic             zf,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, next_state;
  logic   retire_c;
  logic   in_mem_c;
  logic   expired_c;

  // zf qualifies PCWriteCond inside the datapath, not here
  logic unused_zf;
  assign unused_zf = zf;

  assign in_mem_c = is_mem_state(state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clear     (!in_mem_c || mem_ready),
    .enable    (in_mem_c && !mem_ready),
    .expired_c (expired_c)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_RESET;
    else        state <= next_state;
  end

  // Next-state and retire decode
  always_comb begin
    next_state = state;
    retire_c   = 1'b0;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      next_state = S_DECODE;
        else if (expired_c) next_state = S_FAULT;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXEC_R;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      next_state = S_MEM_WB;
        else if (expired_c) next_state = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire_c   = 1'b1;
        end else if (expired_c) begin
          next_state = S_FAULT;
        end
      end
      S_EXEC_R:  next_state = S_R_WB;
      S_ADDI_EX: next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        next_state = S_FETCH;
        retire_c   = 1'b1;
      end
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_RESET;
    endcase
  end

  // Datapath strobes; FETCH qualifies the IR/PC load with mem_ready
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    AluOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    fault       = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM_SH;
        illegal_op = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        AluOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        AluOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        instr_count <= '0;
    else if (retire_c) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected strobe words
// and counter values are queued per instruction, then popped and compared.
module tb_multicycle_control_fsm;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [5:0]       op = 6'd0;
  logic             zf = 1'b0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, AluOp, PCSource;
  logic             illegal_op, fault;
  logic [CNT_W-1:0] instr_count;
  logic [17:0]      ctl_obs;

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .op(op), .zf(zf), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .fault(fault), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  assign ctl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp,
                    PCSource, illegal_op, fault};

  typedef struct {
    string            tag;
    logic             rdy;
    logic [17:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [5:0]       cur_op = 6'd0;
  logic             cur_zf = 1'b0;

  function automatic logic [17:0] mk(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
    input logic [1:0] srcb, aluop, pcsrc,
    input logic ill, flt);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
            srcb, aluop, pcsrc, ill, flt};
  endfunction

  task automatic push(input string tag, input logic rdy, input logic [17:0] ctl,
                      input logic retire);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.ctl = ctl; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (retire) exp_cnt = exp_cnt + CNT_W'(1);
  endtask

  task automatic push_fetch(input logic r);
    push("fetch", r, mk(r,0,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b0);
  endtask

  task automatic push_decode(input logic ill);
    push("decode", 1'b1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,ill,0), 1'b0);
  endtask

  // Pop one expected cycle per negedge, drive its inputs, compare #1 later
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge CLK);
      mem_ready = e.rdy;
      op        = cur_op;
      zf        = cur_zf;
      #1;
      vectors++;
      assert (ctl_obs === e.ctl) else begin
        miscompares++;
        $error("FAIL %s ctl: observed %b expected %b", e.tag, ctl_obs, e.ctl);
      end
      vectors++;
      assert (instr_count === e.cnt) else begin
        miscompares++;
        $error("FAIL %s count: observed %0d expected %0d", e.tag, instr_count, e.cnt);
      end
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic z,
                          input int fetch_stall, input int mem_stall);
    cur_op = o;
    cur_zf = z;
    for (int i = 0; i < fetch_stall; i++) push_fetch(1'b0);
    push_fetch(1'b1);
    case (o)
      6'b000000: begin
        push_decode(1'b0);
        push("exec_r", 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), 1'b0);
        push("r_wb",   1'b1, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0), 1'b1);
      end
      6'b100011: begin
        push_decode(1'b0);
        push("lw_addr", 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'b0);
        for (int i = 0; i < mem_stall; i++)
          push("mem_rd", 1'b0, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
        push("mem_rd", 1'b1, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
        push("mem_wb", 1'b1, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0), 1'b1);
      end
      6'b101011: begin
        push_decode(1'b0);
        push("sw_addr", 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'b0);
        for (int i = 0; i < mem_stall; i++)
          push("mem_wr", 1'b0, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
        push("mem_wr", 1'b1, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b1);
      end
      6'b001000: begin
        push_decode(1'b0);
        push("addi_ex", 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'b0);
        push("addi_wb", 1'b1, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0), 1'b1);
      end
      6'b000100: begin
        push_decode(1'b0);
        push("branch", 1'b1, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0), 1'b1);
      end
      6'b000010: begin
        push_decode(1'b0);
        push("jump", 1'b1, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0), 1'b1);
      end
      default: push_decode(1'b1);
    endcase
    drain();
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    assert (ctl_obs === 18'd0 && instr_count === '0) else begin
      miscompares++;
      $error("FAIL %s: observed ctl %b count %0d expected ctl 0 count 0",
             tag, ctl_obs, instr_count);
    end
  endtask

  task automatic do_reset();
    RST_N     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("in_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_idle("reset_state");
    exp_cnt = '0;
  endtask

  initial begin
    do_reset();

    do_instr(6'b000000, 1'b0, 0, 0);   // R-type, 4 cycles
    do_instr(6'b100011, 1'b0, 0, 3);   // lw with 3 read stalls
    do_instr(6'b101011, 1'b0, 0, 0);   // sw
    do_instr(6'b001000, 1'b0, 0, 0);   // addi
    do_instr(6'b000100, 1'b1, 0, 0);   // beq taken
    do_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
    do_instr(6'b000010, 1'b0, 0, 0);   // j
    do_instr(6'b111111, 1'b0, 0, 0);   // illegal, no retire
    do_instr(6'b001000, 1'b0, 2, 0);   // addi after 2 fetch stalls
    do_instr(6'b101011, 1'b0, 0, 2);   // sw with 2 write stalls

    // Walk the counter to all-ones, then one more retire wraps it
    while (exp_cnt != {CNT_W{1'b1}}) do_instr(6'b000010, 1'b0, 0, 0);
    do_instr(6'b000010, 1'b0, 0, 0);
    @(negedge CLK);
    #1;
    vectors++;
    assert (instr_count === '0) else begin
      miscompares++;
      $error("FAIL wrap: observed %0d expected 0", instr_count);
    end

    // Reset while a store is waiting: MemWrite must drop with RST_N
    do_reset();
    cur_op = 6'b101011;
    push_fetch(1'b1);
    push_decode(1'b0);
    push("sw_addr", 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'b0);
    push("mem_wr",  1'b0, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
    drain();
    @(negedge CLK);
    mem_ready = 1'b0;
    #1;
    vectors++;
    assert (MemWrite === 1'b1) else begin
      miscompares++;
      $error("FAIL mem_wr_hold: observed %b expected 1", MemWrite);
    end
    RST_N = 1'b0;
    #1;
    check_idle("abort_mem_wr");

    // Fetch timeout: four unanswered waits, then sticky fault
    do_reset();
    cur_op = 6'b000000;
    for (int i = 0; i < 4; i++) push_fetch(1'b0);
    for (int i = 0; i < 3; i++)
      push("fault", 1'b1, mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1), 1'b0);
    drain();

    do_reset();   // fault cleared only by reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
